// File: rtl/shuffle_sequencer.sv
// shuffle_sequencer: turns start/stop/show button levels into a decelerating
// train of step pulses for an external 4-bit random generator, captures the
// value shown when a run ends, keeps a two-deep result history and selects
// which value the display shows (live shuffle, latest or previous result).
module shuffle_sequencer #(
  parameter int CNT_W         = 25,
  parameter int INIT_INTERVAL = 4,
  parameter int N_STEPS       = 16,
  parameter int SHOW_CYCLES   = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_show,
  input  logic [3:0] i_rand,
  output logic       o_step,
  output logic [3:0] o_value,
  output logic       o_busy,
  output logic [1:0] o_state
);

  // Counter widths sized so each counter can reach its terminal value.
  localparam int STEP_W = $clog2(N_STEPS + 1);
  localparam int SHOW_W = $clog2(SHOW_CYCLES + 1);

  localparam logic [CNT_W-1:0]  INIT_IV   = CNT_W'(INIT_INTERVAL);
  localparam logic [CNT_W-1:0]  MAX_IV    = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);
  localparam logic [SHOW_W-1:0] SHOW_ONE  = SHOW_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Button edge detection.
  logic start_prev_q, stop_prev_q, show_prev_q;
  logic start_edge, stop_edge, show_edge;

  // Run datapath.
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  interval_q;
  logic [CNT_W-1:0]  interval_dbl;
  logic [CNT_W:0]    interval_wide;
  logic [STEP_W-1:0] steps_q;
  logic              step;
  logic              last_step;

  // Display and result history.
  logic [3:0]        value_q;
  logic [3:0]        value_d;
  logic [3:0]        last_res_q;
  logic [3:0]        prev_res_q;
  logic              have_res_q;

  // SHOW timer.
  logic [SHOW_W-1:0] show_cnt_q;
  logic              show_expired;

  // State transition qualifiers.
  logic              enter_run;
  logic              enter_done;
  logic              enter_show;

  assign start_edge = i_start & ~start_prev_q;
  assign stop_edge  = i_stop  & ~stop_prev_q;
  assign show_edge  = i_show  & ~show_prev_q;

  // A step fires on the last cycle of the current interval; this decodes only
  // registered state, so o_step never depends on a button input.
  assign step      = (state_q == S_RUN) && (cnt_q == (interval_q - CNT_ONE));
  assign last_step = step && (steps_q == LAST_STEP);

  // Interval doubles after each step and saturates at the counter maximum.
  assign interval_wide = {interval_q, 1'b0};
  assign interval_dbl  = interval_wide[CNT_W] ? MAX_IV : interval_wide[CNT_W-1:0];

  // The value loaded on a step edge is what the run captures if it ends now.
  assign value_d = step ? i_rand : value_q;

  assign show_expired = (show_cnt_q == SHOW_LAST);

  assign enter_run  = (state_d == S_RUN)  && (state_q != S_RUN);
  assign enter_done = (state_d == S_DONE) && (state_q == S_RUN);
  assign enter_show = (state_d == S_SHOW) && (state_q != S_SHOW);

  // Previous-level flops for the three buttons.
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // sample pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      show_prev_q  <= 1'b0;
    end else begin
      start_prev_q <= i_start;
      stop_prev_q  <= i_stop;
      show_prev_q  <= i_show;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start has priority over show wherever both are legal.
  // NOTE: state_d gets its default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_RUN;
        end else if (show_edge) begin
          state_d = S_SHOW;
        end
      end
      S_RUN: begin
        if (stop_edge || last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_edge) begin
          state_d = S_RUN;
        end else if (show_edge) begin
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (start_edge) begin
          state_d = S_RUN;
        end else if (show_expired) begin
          state_d = have_res_q ? S_DONE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Interval counter, interval register and step count for the running shuffle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      interval_q <= '0;
      steps_q    <= '0;
    end else if (enter_run) begin
      cnt_q      <= '0;
      interval_q <= INIT_IV;
      steps_q    <= '0;
    end else if (state_q == S_RUN) begin
      if (step) begin
        cnt_q      <= '0;
        interval_q <= interval_dbl;
        steps_q    <= steps_q + STEP_ONE;
      end else begin
        cnt_q      <= cnt_q + CNT_ONE;
      end
    end
  end

  // Live display value: follows the generator on each step, else holds.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      value_q <= 4'h0;
    end else begin
      value_q <= value_d;
    end
  end

  // Result history shifts once per completed run, including a same-cycle step.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_res_q <= 4'h0;
      prev_res_q <= 4'h0;
      have_res_q <= 1'b0;
    end else if (enter_done) begin
      prev_res_q <= last_res_q;
      last_res_q <= value_d;
      have_res_q <= 1'b1;
    end
  end

  // SHOW dwell timer; restarts only on entry, so repeated show edges are inert.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      show_cnt_q <= '0;
    end else if (enter_show) begin
      show_cnt_q <= '0;
    end else if (state_q == S_SHOW) begin
      show_cnt_q <= show_cnt_q + SHOW_ONE;
    end
  end

  // In DONE value_q already equals last_res, so only SHOW needs a separate source.
  assign o_value = (state_q == S_SHOW) ? prev_res_q : value_q;
  assign o_step  = step;
  assign o_busy  = (state_q == S_RUN);
  assign o_state = state_q;

endmodule

// File: tb/tb_shuffle_sequencer.sv
// Directed bench for shuffle_sequencer: step schedule, stop/auto-stop, result
// history through SHOW, SHOW abort, mid-run reset, saturation and edge detect.
module tb_shuffle_sequencer;

  localparam int SC = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, show = 1'b0;
  logic [3:0] rand_v = 4'h9;
  logic       step, busy;
  logic [3:0] value;
  logic [1:0] state;

  logic       s_start = 1'b0, s_stop = 1'b0, s_show = 1'b0;
  logic       s_step, s_busy;
  logic [3:0] s_value;
  logic [1:0] s_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Free-running 4-bit LFSR standing in for the external random generator.
  always @(posedge clk) rand_v <= {rand_v[2:0], rand_v[3] ^ rand_v[2]};

  shuffle_sequencer #(
    .CNT_W(8), .INIT_INTERVAL(4), .N_STEPS(4), .SHOW_CYCLES(SC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_show(show), .i_rand(rand_v), .o_step(step), .o_value(value),
    .o_busy(busy), .o_state(state)
  );

  shuffle_sequencer #(
    .CNT_W(4), .INIT_INTERVAL(4), .N_STEPS(6), .SHOW_CYCLES(2)
  ) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_stop(s_stop),
    .i_show(s_show), .i_rand(rand_v), .o_step(s_step), .o_value(s_value),
    .o_busy(s_busy), .o_state(s_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles (counted from the first RUN cycle) in which the main DUT steps:
  // intervals 4, 8, 16, 32 end at 4, 12, 28, 60 cycles after entry.
  function automatic bit main_step_at(input int t);
    return (t == 3) || (t == 11) || (t == 27) || (t == 59);
  endfunction

  // Caller has just clocked a start edge in. Checks every RUN cycle; raises
  // stop at cycle stop_t (-1: auto-stop), drops start at cycle rel_t.
  task automatic run_main(input int stop_t, input int rel_t,
                          input logic [3:0] v_in, output logic [3:0] v_out);
    logic [3:0] exp_v;
    logic [3:0] cap;
    bit         is_step;
    bit         last;
    exp_v = v_in;
    cap   = 4'h0;
    for (int t = 0; t <= 60; t++) begin
      is_step = main_step_at(t);
      check($sformatf("run state t=%0d", t), state, 1);
      check($sformatf("run busy t=%0d", t), busy, 1);
      check($sformatf("run step t=%0d", t), step, is_step);
      check($sformatf("run value t=%0d", t), value, exp_v);
      if (t == rel_t) start = 1'b0;
      if (t == stop_t) stop = 1'b1;
      if (is_step) cap = rand_v;
      last = (t == 59) || (t == stop_t);
      tick();
      stop = 1'b0;
      if (is_step) exp_v = cap;
      if (last) break;
    end
    check("done state", state, 2);
    check("done busy", busy, 0);
    check("done step", step, 0);
    check("done value", value, exp_v);
    v_out = exp_v;
  endtask

  // From DONE: show edge, prev result for SC cycles (a second show edge is
  // ignored), then back to DONE showing the latest result.
  task automatic show_main(input logic [3:0] p, input logic [3:0] l);
    show = 1'b1;
    tick();
    show = 1'b0;
    for (int i = 0; i < SC; i++) begin
      check($sformatf("show state i=%0d", i), state, 3);
      check($sformatf("show value i=%0d", i), value, p);
      if (i == 3) show = 1'b1;
      if (i == 4) show = 1'b0;
      tick();
    end
    check("show exit state", state, 2);
    check("show exit value", value, l);
  endtask

  logic [3:0] a2, va, vb, vc, vd, s_cap, s_exp;
  int         pulses;
  bit         s_is;
  int         s_states[6] = '{3, 3, 2, 2, 2, 2};

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst state", state, 0);
    check("rst value", value, 0);
    check("rst step", step, 0);
    check("rst busy", busy, 0);
    check("rst sat state", s_state, 0);
    rst_n = 1'b1;
    tick();

    // Stop edge in IDLE is ignored.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("idle stop", state, 0);

    // Start held two cycles: one run, auto-stop after step 4.
    start = 1'b1;
    tick();
    run_main(-1, 1, 4'h0, a2);

    // Two stopped runs, then SHOW displays the older one.
    start = 1'b1;
    tick();
    run_main(28, 0, a2, va);
    start = 1'b1;
    tick();
    run_main(12, 0, va, vb);
    show_main(va, vb);

    // Stop coincides with the terminal step: history shifts exactly once.
    start = 1'b1;
    tick();
    run_main(59, 0, vb, vc);
    show_main(vb, vc);

    // Start edge ten cycles into SHOW aborts it.
    show = 1'b1;
    tick();
    show = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("abort show i=%0d", i), state, 3);
      tick();
    end
    start = 1'b1;
    tick();
    run_main(5, 0, vc, vd);

    // Reset mid-run after step 2.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst state", state, 0);
    check("midrst value", value, 0);
    check("midrst step", step, 0);
    check("midrst busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      if (step) pulses++;
      tick();
    end
    check("midrst no steps", pulses, 0);
    check("midrst idle", state, 0);
    show = 1'b1;
    tick();
    show = 1'b0;
    check("midrst show state", state, 3);
    check("midrst show value", value, 0);
    repeat (SC) tick();
    check("midrst show to idle", state, 0);

    // Saturating instance: intervals 4, 8, 15, 15, 15, 15; start held 5 cycles.
    s_start = 1'b1;
    tick();
    s_cap = 4'h0;
    for (int t = 0; t <= 71; t++) begin
      s_is = (t == 3) || (t == 11) || (t == 26) || (t == 41) || (t == 56) || (t == 71);
      if (t == 4) s_start = 1'b0;
      check($sformatf("sat step t=%0d", t), s_step, s_is);
      check($sformatf("sat state t=%0d", t), s_state, 1);
      if (s_is) s_cap = rand_v;
      tick();
    end
    s_exp = s_cap;
    check("sat done state", s_state, 2);
    check("sat done value", s_value, s_exp);

    // Stop held 5 cycles is one event.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      check($sformatf("sat2 step t=%0d", t), s_step, (t == 3));
      if (t == 4) s_stop = 1'b1;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sat stop held i=%0d", i), s_state, 2);
      check($sformatf("sat stop step i=%0d", i), s_step, 0);
      tick();
    end
    s_stop = 1'b0;

    // Show held 5 cycles outlasts SHOW but does not re-enter it.
    s_show = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) s_show = 1'b0;
      check($sformatf("sat show held i=%0d", i), s_state, s_states[i]);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
